// File: rtl/modular_square_ggg_normalize.sv
// GGG modular-square normalizer: captures a redundant-form square and
// streams canonical words LSW-first while rippling the inter-word carry
// one word per accepted beat.
// Optional feature macro: GGG_NORM_OVERFLOW_CHECK_EN. When it is defined,
// overflow flags a non-zero final carry. When it is undefined, overflow is 0.
//
// Handshake: a beat transfers on a rising edge where out_valid && out_ready.
// out_valid, once raised, stays high until its beat transfers. out_word,
// out_idx, out_last and carry_out hold while the beat is not taken.
// out_valid is purely registered and never depends on out_ready.
module modular_square_ggg_normalize #(
  parameter int NUM_ELEMENTS = 21,
  parameter int WORD_LEN     = 50,
  parameter int CARRY_LEN    = 2,
  parameter int IDX_LEN      = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [NUM_ELEMENTS-1:0][WORD_LEN:0]    sq_in,
  output logic                                   busy,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [WORD_LEN-1:0]                    out_word,
  output logic [IDX_LEN-1:0]                     out_idx,
  output logic                                   out_last,
  output logic [CARRY_LEN-1:0]                   carry_out,
  output logic                                   overflow,
  output logic                                   dbg_state
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [IDX_LEN-1:0] LAST_IDX = IDX_LEN'(NUM_ELEMENTS - 1);
  // A WORD_LEN+1-bit word plus a carry of up to 2 can reach 2^(WORD_LEN+1)+1.
  // The extra bit keeps that sum from being truncated.
  localparam int SUM_W = WORD_LEN + 2;

  logic [0:0]                             state_q, state_d;
  logic [NUM_ELEMENTS-1:0][WORD_LEN:0]    buf_q, buf_d;
  logic [WORD_LEN-1:0]                    word_q, word_d;
  logic [IDX_LEN-1:0]                     idx_q, idx_d;
  logic [CARRY_LEN-1:0]                   carry_q, carry_d;

  logic                                   is_last;
  logic                                   start_acc;
  logic                                   step;
  logic [IDX_LEN-1:0]                     idx_inc;
  logic [SUM_W-1:0]                       sum;

  assign is_last   = (idx_q == LAST_IDX);
  assign start_acc = (state_q == S_IDLE) && start;
  assign step      = (state_q == S_RUN) && out_ready && !is_last;
  // idx_inc is clamped so the buffer read never goes past the top word.
  assign idx_inc   = is_last ? idx_q : idx_q + IDX_LEN'(1);
  assign sum       = SUM_W'(buf_q[idx_inc]) + SUM_W'(carry_q);

  // Next-state logic: capture on start, ripple one word per accepted beat.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    word_d  = word_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          buf_d   = sq_in;
          word_d  = sq_in[0][WORD_LEN-1:0];
          carry_d = CARRY_LEN'(sq_in[0][WORD_LEN]);
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      default: begin
        if (out_ready) begin
          if (is_last) begin
            state_d = S_IDLE;
          end else begin
            word_d  = sum[WORD_LEN-1:0];
            carry_d = sum[WORD_LEN +: CARRY_LEN];
            idx_d   = idx_inc;
          end
        end
      end
    endcase
  end

  // State registers, synchronously cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      carry_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
    end
  end

`ifdef GGG_NORM_OVERFLOW_CHECK_EN
  logic ovf_q;
  // The flag is set when the top word is loaded with a non-zero carry.
  // An accepted start re-arms the flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (start_acc) begin
      ovf_q <= (LAST_IDX == '0) && (carry_d != '0);
    end else if (step) begin
      ovf_q <= ovf_q | ((idx_d == LAST_IDX) && (carry_d != '0));
    end
  end
  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign busy      = (state_q == S_RUN);
  assign out_valid = (state_q == S_RUN);
  assign out_word  = word_q;
  assign out_idx   = idx_q;
  assign out_last  = (state_q == S_RUN) && is_last;
  assign carry_out = out_last ? carry_q : '0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_modular_square_ggg_normalize.sv
// Bench for modular_square_ggg_normalize. It streams directed and random
// redundant squares through the block. The expected words come from the
// full integer value of the input, sliced into WORD_LEN-bit digits.
module tb_modular_square_ggg_normalize;

  localparam int NE  = 21;
  localparam int WL  = 50;
  localparam int CL  = 2;
  localparam int IL  = $clog2(NE);
  localparam int TOT = WL * NE + CL + 4;
`ifdef GGG_NORM_OVERFLOW_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic                       clk;
  logic                       reset;
  logic                       start;
  logic [NE-1:0][WL:0]        sq_in;
  logic                       busy;
  logic                       out_valid;
  logic                       out_ready;
  logic [WL-1:0]              out_word;
  logic [IL-1:0]              out_idx;
  logic                       out_last;
  logic [CL-1:0]              carry_out;
  logic                       overflow;
  logic                       dbg_state;

  logic [WL-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  modular_square_ggg_normalize #(
    .NUM_ELEMENTS(NE), .WORD_LEN(WL), .CARRY_LEN(CL)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .sq_in(sq_in),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_idx(out_idx), .out_last(out_last),
    .carry_out(carry_out), .overflow(overflow), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_busy"},  64'(busy),      64'd0);
    check({tag, "_word"},  64'(out_word),  64'd0);
    check({tag, "_idx"},   64'(out_idx),   64'd0);
    check({tag, "_last"},  64'(out_last),  64'd0);
    check({tag, "_cout"},  64'(carry_out), 64'd0);
    check({tag, "_ovf"},   64'(overflow),  64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  function automatic logic [NE-1:0][WL:0] rand_vec();
    logic [NE-1:0][WL:0] v;
    for (int i = 0; i < NE; i++) v[i] = {$urandom(), $urandom()};
    return v;
  endfunction

  // Drives one run: optional fixed stall at stall_at, random back-pressure,
  // stray start pulses, or a reset at abort_at.
  task automatic run_case(input string name, input logic [NE-1:0][WL:0] v,
                          input int stall_at, input bit rand_ready,
                          input bit poke_start, input int abort_at);
    logic [TOT-1:0] total;
    logic [CL-1:0]  exp_c;
    logic [WL-1:0]  exp_w;
    logic [WL-1:0]  held_w;
    logic [IL-1:0]  held_i;
    bit             was_stall;
    bit             stall;
    bit             exp_ovf;
    int             idx_exp;
    int             stall_left;
    int             budget;
    total = '0;
    for (int i = 0; i < NE; i++) total = total + (TOT'(v[i]) << (WL * i));
    exp_q.delete();
    for (int i = 0; i < NE; i++) exp_q.push_back(total[WL*i +: WL]);
    exp_c   = total[WL*NE +: CL];
    exp_ovf = OVF_EN && (exp_c != '0);

    @(negedge clk);
    sq_in = v; start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    sq_in = rand_vec();  // captured copy must be used, not the live input
    check({name, "_busy0"}, 64'(busy), 64'd1);
    idx_exp = 0; stall_left = 3; was_stall = 0; budget = 400;
    while (exp_q.size() > 0 && budget > 0) begin
      budget--;
      start = 1'b0;
      check({name, "_valid"}, 64'(out_valid), 64'd1);
      if (idx_exp == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_zero({name, "_abort"});
        exp_q.delete();
        @(negedge clk);
        check({name, "_abort_quiet"}, 64'(out_valid), 64'd0);
        return;
      end
      if (was_stall) begin
        check({name, "_hold_word"}, 64'(out_word), 64'(held_w));
        check({name, "_hold_idx"},  64'(out_idx),  64'(held_i));
      end
      stall = (idx_exp == stall_at && stall_left > 0) ||
              (rand_ready && $urandom_range(0, 2) == 0);
      if (stall) begin
        if (idx_exp == stall_at && stall_left > 0) stall_left--;
        out_ready = 1'b0;
        held_w = out_word; held_i = out_idx; was_stall = 1;
      end else begin
        out_ready = 1'b1;
        was_stall = 0;
        exp_w = exp_q.pop_front();
        check({name, "_word"}, 64'(out_word), 64'(exp_w));
        check({name, "_idx"},  64'(out_idx),  64'(idx_exp));
        check({name, "_last"}, 64'(out_last), 64'(idx_exp == NE - 1));
        check({name, "_cout"}, 64'(carry_out), (idx_exp == NE - 1) ? 64'(exp_c) : 64'd0);
        check({name, "_ovf"},  64'(overflow), (idx_exp == NE - 1) ? 64'(exp_ovf) : 64'd0);
        if (poke_start && (idx_exp == 3 || idx_exp == NE - 1)) start = 1'b1;
        idx_exp++;
      end
      @(negedge clk);
    end
    start = 1'b0; out_ready = 1'b0;
    if (budget == 0) check({name, "_timeout"}, 64'd0, 64'd1);
    check({name, "_end_valid"}, 64'(out_valid), 64'd0);
    check({name, "_end_busy"},  64'(busy),      64'd0);
    check({name, "_end_last"},  64'(out_last),  64'd0);
    check({name, "_end_cout"},  64'(carry_out), 64'd0);
    check({name, "_end_ovf"},   64'(overflow),  64'(exp_ovf));
    @(negedge clk);
    check({name, "_stay_idle"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [NE-1:0][WL:0] v;
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; sq_in = '0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle_zero("post_reset");

    v = '0;
    run_case("zeros", v, -1, 0, 0, -1);
    for (int i = 0; i < NE; i++) v[i] = {1'b1, {WL{1'b0}}};
    run_case("pow50", v, -1, 0, 0, -1);
    for (int i = 0; i < NE; i++) v[i] = {(WL+1){1'b1}};
    run_case("allones", v, -1, 0, 0, -1);
    run_case("stall5", rand_vec(), 5, 0, 0, -1);
    run_case("poke", rand_vec(), -1, 0, 1, -1);
    run_case("abort10", rand_vec(), -1, 0, 0, 10);
    run_case("after_abort", rand_vec(), -1, 0, 0, -1);
    for (int k = 0; k < 4; k++) run_case("rand_bp", rand_vec(), -1, 1, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
